dpram_march_bist: RTL and testbench
===================================

# dpram_march_bist

Built-in self-test initiator that drives one read/write port of the dual-port RAM (`dpram_r2w1_wt` class, registered synchronous read, 1-cycle latency) through a March C- style sequence. It checks every returned word and reports pass/fail with the first failing address and data. It sits beside the RAM in the MyHDL/GHDL co-simulation suite and as a power-on memory check in synthesized designs. It is the active counterpart to the RAM: it issues the port commands and consumes the read data.

## Interface
- ADDR_W, 12, RAM address width; depth N = 2^ADDR_W
- DATA_W, 16, RAM data width
- PATTERN, 16'h5A5A, background word "D0"; "D1" = ~PATTERN (DATA_W bits)

Ports:
- clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse or level; accepted only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE is entered
- done  out  1  high in DONE; held until next accepted start or reset
- pass  out  1  valid when done=1; 1 = no mismatch
- err_addr  out  ADDR_W  address of first mismatch
- err_data  out  DATA_W  word read at first mismatch
- m_ce  out  1  RAM port enable
- m_we  out  1  RAM write enable
- m_addr  out  ADDR_W  RAM address
- m_write  out  DATA_W  RAM write data
- m_read  in  DATA_W  RAM read data, valid the cycle after a read command

## Operation
- All m_* outputs and status outputs are registered.
- Reset values: m_ce=0, m_we=0, m_addr=0, m_write=0, busy=0, done=0, pass=0, err_addr=0, err_data=0; state IDLE.
- FSM: IDLE -> E0 -> E1 -> E2 -> E3 -> FLUSH -> DONE. Any mismatch goes to DONE.
- E0, up: write D0 at addresses 0..N-1, one address per cycle.
- E1, up: for each address, read (expect D0), then write D1. Two cycles per address.
- E2, down: for each address N-1..0, read (expect D1), then write D0. Two cycles per address.
- E3, down: read (expect D0), one address per cycle, pipelined.
- FLUSH: one cycle, m_ce=0; compares the last E3 read.
- Read cycle: m_ce=1, m_we=0. Write cycle: m_ce=1, m_we=1, m_write = expected word.
- Compare: m_read is sampled one cycle after each read command and checked against the expected word for that read. The expected word and address are carried in a 1-stage pipeline.
- E1/E2: the compare happens in the write cycle of the same address.
- E3: the compare overlaps the next read.
- First mismatch: latch err_addr and err_data, pass=0. In the same clock edge, force m_ce=0 and m_we=0, then go to DONE. No further RAM access follows.
- DONE with no mismatch: pass=1, err_* unchanged from reset/start values.
- Accepted start clears done, pass, err_addr and err_data.
- Address counter wraps internally. Element transitions happen at addr N-1 (up) or 0 (down), with no idle cycle between elements.
- start while busy or in FLUSH is ignored. start in DONE is accepted (restart).
- Reset at any point aborts immediately: next cycle all outputs are at reset values and RAM contents are left as-is.

## Timing
- Cycle 0 is the edge where start=1 is sampled in IDLE. busy=1 and the first E0 write are on m_* from cycle 1.
- Access cycles: E0 N, E1 2N, E2 2N, E3 N, FLUSH 1; total 6N+1.
- Fault-free run: done=1, busy=0 from cycle 6N+2. busy is high for exactly 6N+1 cycles.
- Read latency is fixed at 1. Write-through behaviour of the RAM is not relied on, because no address is read in the same cycle it is written.
- Mismatch detected at the edge ending cycle t: done=1, busy=0 and m_ce=0 visible in cycle t+1.

## Test plan
- ADDR_W=4, fault-free behavioural RAM, start pulse -> busy high 97 cycles, then done=1, pass=1. Exactly 16 E0 writes, 64 accesses in E1+E2, 16 E3 reads.
- ADDR_W=4, bit0 of address 5 stuck at 1 -> fail in E1 at addr 5. err_addr=5, err_data=16'h5A5B, pass=0, no RAM access after the failing compare.
- ADDR_W=4, address 9 write-disabled after E0 (holds D0) -> fail in E2. err_addr=9, err_data=16'h5A5A, pass=0.
- Fault-free run with reset asserted in E2 -> next cycle m_ce=0, busy=0, done=0. A new start then completes with pass=1 after 97 cycles.
- start re-pulsed during E1 -> ignored, total busy duration still 97 cycles. start pulsed in DONE -> done/pass clear, second run passes.
- Check address order: E1 addresses ascend 0..15 and E2 addresses descend 15..0. m_write equals 16'hA5A5 in E1 writes and 16'h5A5A in E2 writes.

Source files
------------

// File: rtl/dpram_march_bist.sv
// March C- built-in self-test initiator for one synchronous-read RAM port.
// Issues E0..E3 commands, checks each read one cycle later, reports the first mismatch.
module dpram_march_bist #(
    parameter int                ADDR_W  = 12,
    parameter int                DATA_W  = 16,
    parameter logic [DATA_W-1:0] PATTERN = 16'h5A5A
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data,
    output logic              m_ce,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_write,
    input  logic [DATA_W-1:0] m_read,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_E0    = 3'd1,
        S_E1    = 3'd2,
        S_E2    = 3'd3,
        S_E3    = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [DATA_W-1:0] D0       = PATTERN;
    localparam logic [DATA_W-1:0] D1       = ~PATTERN;
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    // state_q names the element of the command currently on the m_* bus.
    state_t              state_q, state_d;
    logic                m_ce_q, m_ce_d, m_we_q, m_we_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_write_q, m_write_d;
    logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
    logic [DATA_W-1:0]   err_data_q, err_data_d;
    logic                chk_valid_q, chk_valid_d;
    logic [DATA_W-1:0]   chk_exp_q, chk_exp_d;
    logic [ADDR_W-1:0]   chk_addr_q, chk_addr_d;
    logic [DATA_W-1:0]   exp_now;
    logic                mismatch;

    always_comb begin
        exp_now = D0;
        if (state_q == S_E2) exp_now = D1;
    end

    // Gating with busy_q ignores a stale compare left over when a run ends early.
    assign mismatch = busy_q && chk_valid_q && (m_read != chk_exp_q);

    always_comb begin
        state_d     = state_q;
        m_ce_d      = 1'b0;
        m_we_d      = 1'b0;
        m_addr_d    = m_addr_q;
        m_write_d   = m_write_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_addr_d  = err_addr_q;
        err_data_d  = err_data_q;
        chk_valid_d = m_ce_q && !m_we_q;
        chk_exp_d   = exp_now;
        chk_addr_d  = m_addr_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_E0;
                    m_ce_d     = 1'b1;
                    m_we_d     = 1'b1;
                    m_addr_d   = '0;
                    m_write_d  = D0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_addr_d = '0;
                    err_data_d = '0;
                end
            end
            S_E0: begin
                m_ce_d = 1'b1;
                if (m_addr_q == ADDR_MAX) begin
                    state_d  = S_E1;
                    m_addr_d = '0;
                end else begin
                    m_we_d    = 1'b1;
                    m_addr_d  = m_addr_q + ADDR_W'(1);
                    m_write_d = D0;
                end
            end
            S_E1: begin
                m_ce_d = 1'b1;
                if (!m_we_q) begin
                    m_we_d    = 1'b1;
                    m_write_d = D1;
                end else if (m_addr_q == ADDR_MAX) begin
                    state_d = S_E2;
                end else begin
                    m_addr_d = m_addr_q + ADDR_W'(1);
                end
            end
            S_E2: begin
                m_ce_d = 1'b1;
                if (!m_we_q) begin
                    m_we_d    = 1'b1;
                    m_write_d = D0;
                end else if (m_addr_q == '0) begin
                    state_d  = S_E3;
                    m_addr_d = ADDR_MAX;
                end else begin
                    m_addr_d = m_addr_q - ADDR_W'(1);
                end
            end
            S_E3: begin
                if (m_addr_q == '0) begin
                    state_d = S_FLUSH;
                end else begin
                    m_ce_d   = 1'b1;
                    m_addr_d = m_addr_q - ADDR_W'(1);
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (mismatch) begin
            state_d     = S_DONE;
            m_ce_d      = 1'b0;
            m_we_d      = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            pass_d      = 1'b0;
            err_addr_d  = chk_addr_q;
            err_data_d  = m_read;
            chk_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            m_ce_q      <= 1'b0;
            m_we_q      <= 1'b0;
            m_addr_q    <= '0;
            m_write_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_addr_q  <= '0;
            err_data_q  <= '0;
            chk_valid_q <= 1'b0;
            chk_exp_q   <= '0;
            chk_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            m_ce_q      <= m_ce_d;
            m_we_q      <= m_we_d;
            m_addr_q    <= m_addr_d;
            m_write_q   <= m_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_addr_q  <= err_addr_d;
            err_data_q  <= err_data_d;
            chk_valid_q <= chk_valid_d;
            chk_exp_q   <= chk_exp_d;
            chk_addr_q  <= chk_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_addr  = err_addr_q;
    assign err_data  = err_data_q;
    assign m_ce      = m_ce_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_write   = m_write_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dpram_march_bist.sv
// Bench for dpram_march_bist: behavioural RAM with injectable faults, March access
// trace rebuilt from element loops, randomized stuck-at faults and start timing.
module tb_dpram_march_bist;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int N = 1 << AW;
  localparam logic [DW-1:0] PAT = 16'h5A5A;
  localparam int TW = 1 + AW + DW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, pass, m_ce, m_we;
  logic [AW-1:0] err_addr, m_addr;
  logic [DW-1:0] err_data, m_write, m_read;
  logic [2:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;

  dpram_march_bist #(.ADDR_W(AW), .DATA_W(DW), .PATTERN(PAT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_addr(err_addr), .err_data(err_data), .m_ce(m_ce), .m_we(m_we),
    .m_addr(m_addr), .m_write(m_write), .m_read(m_read), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // behavioural RAM, registered read, with stuck-at-1 and blocked-write faults
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rd_q = '0;
  logic sa_en = 1'b0, wd_en = 1'b0;
  logic [AW-1:0] sa_addr = '0, wd_addr = '0;
  int sa_bit = 0;
  logic rec_en = 1'b0;
  logic [TW-1:0] act_q[$];
  logic [TW-1:0] exp_q[$];

  assign m_read = rd_q;

  always @(posedge clk) begin
    if (m_ce) begin
      if (m_we) begin
        if (!(wd_en && m_addr == wd_addr && m_write != PAT))
          mem[m_addr] <= m_write | ((sa_en && m_addr == sa_addr) ? DW'(1) << sa_bit : '0);
      end else begin
        rd_q <= mem[m_addr];
      end
    end
    if (rec_en && m_ce) act_q.push_back({m_we, m_addr, m_we ? m_write : DW'(0)});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference access sequence of a full March C- run, cut to the first len accesses
  task automatic build_exp(input int len);
    exp_q.delete();
    for (int a = 0; a < N; a++) exp_q.push_back({1'b1, AW'(a), PAT});
    for (int a = 0; a < N; a++) begin
      exp_q.push_back({1'b0, AW'(a), DW'(0)});
      exp_q.push_back({1'b1, AW'(a), ~PAT});
    end
    for (int a = N - 1; a >= 0; a--) begin
      exp_q.push_back({1'b0, AW'(a), DW'(0)});
      exp_q.push_back({1'b1, AW'(a), PAT});
    end
    for (int a = N - 1; a >= 0; a--) exp_q.push_back({1'b0, AW'(a), DW'(0)});
    while (exp_q.size() > len) void'(exp_q.pop_back());
  endtask

  task automatic compare_trace(input string tag);
    int n;
    check({tag, "_len"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_acc%0d", tag, i), 32'(act_q[i]), 32'(exp_q[i]));
  endtask

  // pulse start, optionally re-pulse at busy cycle pulse_at, count busy cycles until done
  task automatic run(input string tag, input int pulse_at, output int bc);
    act_q.delete();
    rec_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bc = 0;
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_done"}, done, 0);
    check({tag, "_start_pass"}, pass, 0);
    check({tag, "_start_err"}, {err_addr, err_data}, 0);
    while (!done && bc < 400) begin
      if (busy) bc++;
      start = (bc == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_low"}, busy, 0);
    repeat (3) @(negedge clk);
    rec_en = 1'b0;
    check({tag, "_idle_ce"}, m_ce, 0);
    check({tag, "_done_held"}, done, 1);
  endtask

  task automatic run_fault(input string tag, input logic [AW-1:0] fa, input logic [DW-1:0] fdata,
                           input bit in_e1);
    int bc, t, len;
    if (in_e1) begin
      t = N + 2 + 2 * fa;
      len = N + 2 * fa + 2;
    end else begin
      t = 3 * N + 2 + 2 * (N - 1 - fa);
      len = 3 * N + 2 * (N - 1 - fa) + 2;
    end
    run(tag, -1, bc);
    check({tag, "_busy_cycles"}, bc, t);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_addr"}, err_addr, fa);
    check({tag, "_err_data"}, err_data, fdata);
    build_exp(len);
    compare_trace(tag);
  endtask

  initial begin
    int bc, a, b;
    logic [DW-1:0] fd;

    // reset
    repeat (3) @(negedge clk);
    check("rst_outputs", {m_ce, m_we, busy, done, pass}, 0);
    check("rst_bus", {m_addr, m_write, err_addr, err_data}, 0);
    reset = 1'b0;
    repeat ($urandom_range(1, 5)) @(negedge clk);

    // fault-free run, full access order
    run("clean", -1, bc);
    check("clean_busy_cycles", bc, 6 * N + 1);
    check("clean_pass", pass, 1);
    check("clean_err", {err_addr, err_data}, 0);
    build_exp(6 * N);
    compare_trace("clean");

    // restart from DONE with start re-pulsed during E1
    repeat ($urandom_range(0, 4)) @(negedge clk);
    run("restart", N + 5, bc);
    check("restart_busy_cycles", bc, 6 * N + 1);
    check("restart_pass", pass, 1);

    // stuck-at-1 bit0 at address 5 -> E1 failure
    sa_en = 1'b1; sa_addr = 5; sa_bit = 0;
    run_fault("sa5", 4'd5, 16'h5A5B, 1'b1);
    sa_en = 1'b0;

    // address 9 refuses D1 writes after E0 -> E2 failure
    wd_en = 1'b1; wd_addr = 9;
    run_fault("wd9", 4'd9, 16'h5A5A, 1'b0);
    wd_en = 1'b0;

    // random stuck-at-1 faults; element of failure follows the pattern bit
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(0, N - 1);
      b = $urandom_range(0, DW - 1);
      sa_en = 1'b1; sa_addr = AW'(a); sa_bit = b;
      if (PAT[b] == 1'b0) begin
        fd = PAT | (DW'(1) << b);
        run_fault($sformatf("rnd%0d", k), AW'(a), fd, 1'b1);
      end else begin
        fd = ~PAT | (DW'(1) << b);
        run_fault($sformatf("rnd%0d", k), AW'(a), fd, 1'b0);
      end
      sa_en = 1'b0;
    end

    // reset in the middle of E2 aborts; a fresh run then passes
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * N + $urandom_range(2, 2 * N - 2)) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", {m_ce, m_we, busy, done, pass}, 0);
    check("abort_bus", {m_addr, m_write, err_addr, err_data}, 0);
    reset = 1'b0;
    @(negedge clk);
    run("after_abort", -1, bc);
    check("after_abort_busy_cycles", bc, 6 * N + 1);
    check("after_abort_pass", pass, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
